pipe_control_unit: RTL



---
 rtl/pipe_ctrl_pkg.sv | 51 +++++
 rtl/pipe_control_unit_decode.sv | 42 ++++
 rtl/pipe_control_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined control unit: opcodes, FSM states,
// the per-stage control bundle and the bubble value.
package pipe_ctrl_pkg;

    localparam int CTRL_ALU_OP_W = 2;
    localparam int CTRL_RW_W     = 2;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_BGT   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b0111;
    localparam logic [3:0] OP_LBU   = 4'b1010;
    localparam logic [3:0] OP_SB    = 4'b1011;
    localparam logic [3:0] OP_LW    = 4'b1100;
    localparam logic [3:0] OP_SW    = 4'b1101;
    localparam logic [3:0] OP_ARITH = 4'b1111;

    localparam logic [1:0] BR_EQ = 2'b01;
    localparam logic [1:0] BR_GT = 2'b10;
    localparam logic [1:0] BR_LT = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_EXC    = 2'd2
    } state_t;

    typedef struct packed {
        logic [CTRL_ALU_OP_W-1:0] alu_op;
        logic [1:0]               mux_a;
        logic [1:0]               mux_b;
        logic                     mux_c;
        logic [CTRL_RW_W-1:0]     reg_write;
        logic                     mem_write;
        logic                     byte_en;
        logic                     is_load;
        logic                     is_arith;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    function automatic logic branch_taken(input logic [3:0] op, input logic [1:0] res);
        return (op == OP_BGT && res == BR_GT) ||
               (op == OP_BLT && res == BR_LT) ||
               (op == OP_BEQ && res == BR_EQ);
    endfunction

endpackage

// File: rtl/pipe_control_unit_decode.sv
// Combinational ID-stage decoder: opcode to control bundle. Branches, jmp, halt
// and unused opcodes all decode to a bubble.
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [3:0]   i_opcode,
    output ctrl_bundle_t o_bundle
);

    always_comb begin
        o_bundle = BUBBLE;
        case (i_opcode)
            OP_ARITH: begin
                o_bundle.alu_op    = 2'b01;
                o_bundle.mux_c     = 1'b1;
                o_bundle.reg_write = 2'b11;
                o_bundle.is_arith  = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                o_bundle.alu_op    = (i_opcode == OP_ORI) ? 2'b10 : 2'b00;
                o_bundle.mux_b     = 2'b11;
                o_bundle.mux_c     = 1'b1;
                o_bundle.reg_write = 2'b11;
            end
            OP_LBU, OP_LW: begin
                o_bundle.alu_op    = 2'b11;
                o_bundle.mux_a     = 2'b11;
                o_bundle.reg_write = 2'b11;
                o_bundle.byte_en   = (i_opcode == OP_LBU);
                o_bundle.is_load   = 1'b1;
            end
            OP_SB, OP_SW: begin
                o_bundle.alu_op    = 2'b11;
                o_bundle.mux_a     = 2'b11;
                o_bundle.mem_write = 1'b1;
                o_bundle.byte_en   = (i_opcode == OP_SB);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control unit: ID decode, EX/MEM/WB bundle registers, hazard detection
// and RUN/HALTED/EXC FSM. Define PIPE_PERF_CNT_EN to add stall/flush counters.
module pipe_control_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int RADDR_W  = 4,
    parameter int ALU_OP_W = CTRL_ALU_OP_W,
    parameter int RW_W     = CTRL_RW_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [3:0]          id_opcode,
    input  logic [RADDR_W-1:0]  id_rs,
    input  logic [RADDR_W-1:0]  id_rt,
    input  logic [RADDR_W-1:0]  id_rd,
    input  logic [1:0]          branch_result,
    input  logic                overflow_flag,
    input  logic                resume,
`ifdef PIPE_PERF_CNT_EN
    output logic [15:0]         stall_cnt,
    output logic [15:0]         flush_cnt,
`endif
    output logic                pc_write,
    output logic                pc_op,
    output logic                b_jmp,
    output logic                exc_vec,
    output logic                if_flush,
    output logic                id_flush,
    output logic                ex_flush,
    output logic                halt,
    output logic                exc_taken,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic [1:0]          ex_mux_a,
    output logic [1:0]          ex_mux_b,
    output logic [RADDR_W-1:0]  ex_rd,
    output logic                mem_write,
    output logic                mem_byte_en,
    output logic                wb_mux_c,
    output logic [RW_W-1:0]     wb_reg_write,
    output logic [RADDR_W-1:0]  wb_rd
);

    state_t               r_state, w_state_nxt;
    ctrl_bundle_t         w_id_bndl, r_bndl_p1;
    logic [RADDR_W-1:0]   r_rd_p1, r_rd_p2, r_rd_p3;
    logic                 r_mem_write_p2, r_byte_en_p2, r_mux_c_p2, r_mux_c_p3;
    logic [CTRL_RW_W-1:0] r_rw_p2, r_rw_p3;
    logic                 w_ovf, w_load_use, w_ex_bubble;

    ctrl_decode u_decode (
        .i_opcode (id_opcode),
        .o_bundle (w_id_bndl)
    );

    assign w_ovf      = (r_state == ST_RUN) && r_bndl_p1.is_arith && overflow_flag;
    assign w_load_use = (r_state == ST_RUN) && id_valid && r_bndl_p1.is_load &&
                        (r_rd_p1 == id_rs || r_rd_p1 == id_rt);
    assign w_ex_bubble = !id_valid || (r_state != ST_RUN) || w_ovf || w_load_use;

    always_comb begin
        w_state_nxt = r_state;
        pc_write    = 1'b1;
        pc_op       = 1'b0;
        b_jmp       = 1'b0;
        exc_vec     = 1'b0;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        ex_flush    = 1'b0;
        halt        = 1'b0;
        exc_taken   = 1'b0;
        if (!reset) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    // A stalled halt waits until the load-use bubble has been inserted
                    if (w_ovf) begin
                        if_flush    = 1'b1;
                        id_flush    = 1'b1;
                        ex_flush    = 1'b1;
                        w_state_nxt = ST_EXC;
                    end else if (w_load_use) begin
                        pc_write = 1'b0;
                        ex_flush = 1'b1;
                    end else if (id_valid && id_opcode == OP_HALT) begin
                        w_state_nxt = ST_HALTED;
                    end else if (id_valid && branch_taken(id_opcode, branch_result)) begin
                        pc_op    = 1'b1;
                        b_jmp    = 1'b1;
                        if_flush = 1'b1;
                    end else if (id_valid && id_opcode == OP_JMP) begin
                        pc_op    = 1'b1;
                        if_flush = 1'b1;
                    end
                end
                ST_HALTED: begin
                    pc_write = 1'b0;
                    halt     = 1'b1;
                    if (resume) w_state_nxt = ST_RUN;
                end
                ST_EXC: begin
                    exc_taken   = 1'b1;
                    exc_vec     = 1'b1;
                    pc_op       = 1'b1;
                    if_flush    = 1'b1;
                    id_flush    = 1'b1;
                    w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= ST_RUN;
            r_bndl_p1      <= BUBBLE;
            r_rd_p1        <= '0;
            r_mem_write_p2 <= 1'b0;
            r_byte_en_p2   <= 1'b0;
            r_mux_c_p2     <= 1'b0;
            r_rw_p2        <= '0;
            r_rd_p2        <= '0;
            r_mux_c_p3     <= 1'b0;
            r_rw_p3        <= '0;
            r_rd_p3        <= '0;
        end else begin
            r_state <= w_state_nxt;
            // ID -> EX
            r_bndl_p1 <= w_ex_bubble ? BUBBLE : w_id_bndl;
            r_rd_p1   <= w_ex_bubble ? '0 : id_rd;
            // EX -> MEM: an overflowing instruction must not write back
            r_mem_write_p2 <= r_bndl_p1.mem_write;
            r_byte_en_p2   <= r_bndl_p1.byte_en;
            r_mux_c_p2     <= r_bndl_p1.mux_c;
            r_rw_p2        <= w_ovf ? '0 : r_bndl_p1.reg_write;
            r_rd_p2        <= r_rd_p1;
            // MEM -> WB
            r_mux_c_p3 <= r_mux_c_p2;
            r_rw_p3    <= r_rw_p2;
            r_rd_p3    <= r_rd_p2;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (r_state == ST_RUN && !pc_write && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (if_flush && flush_cnt != 16'hFFFF)
                flush_cnt <= flush_cnt + 16'd1;
        end
    end
`endif

    assign ex_alu_op    = ALU_OP_W'(r_bndl_p1.alu_op);
    assign ex_mux_a     = r_bndl_p1.mux_a;
    assign ex_mux_b     = r_bndl_p1.mux_b;
    assign ex_rd        = r_rd_p1;
    assign mem_write    = r_mem_write_p2;
    assign mem_byte_en  = r_byte_en_p2;
    assign wb_mux_c     = r_mux_c_p3;
    assign wb_reg_write = RW_W'(r_rw_p3);
    assign wb_rd        = r_rd_p3;

endmodule
